// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data-memory port.
// The arbiter takes the slave view; whatever drives requests and the memory
// responses (core, loader, memory model) takes the master view.
interface dmem_port_arbiter_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_BITS    = 32,
  parameter int MAX_OUTSTANDING = 4
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  // requester 0 (core)
  logic                    r0_read;
  logic                    r0_write;
  logic [BW-1:0]           r0_byte_en;
  logic [ADDRESS_BITS-1:0] r0_address_in;
  logic [DATA_WIDTH-1:0]   r0_data_in;
  logic                    r0_ready;
  logic                    r0_valid;
  logic [DATA_WIDTH-1:0]   r0_data_out;
  logic [ADDRESS_BITS-1:0] r0_address_out;

  // requester 1 (host/loader)
  logic                    r1_read;
  logic                    r1_write;
  logic [BW-1:0]           r1_byte_en;
  logic [ADDRESS_BITS-1:0] r1_address_in;
  logic [DATA_WIDTH-1:0]   r1_data_in;
  logic                    r1_ready;
  logic                    r1_valid;
  logic [DATA_WIDTH-1:0]   r1_data_out;
  logic [ADDRESS_BITS-1:0] r1_address_out;

  // shared memory port
  logic                    mem_read;
  logic                    mem_write;
  logic [BW-1:0]           mem_byte_en;
  logic [ADDRESS_BITS-1:0] mem_address_in;
  logic [DATA_WIDTH-1:0]   mem_data_in;
  logic                    mem_ready;
  logic                    mem_valid;
  logic [DATA_WIDTH-1:0]   mem_data_out;
  logic [ADDRESS_BITS-1:0] mem_address_out;

  // status
  logic [CW-1:0]           outstanding;
  logic                    resp_error;

  modport slave (
    input  r0_read, r0_write, r0_byte_en, r0_address_in, r0_data_in,
    output r0_ready, r0_valid, r0_data_out, r0_address_out,
    input  r1_read, r1_write, r1_byte_en, r1_address_in, r1_data_in,
    output r1_ready, r1_valid, r1_data_out, r1_address_out,
    output mem_read, mem_write, mem_byte_en, mem_address_in, mem_data_in,
    input  mem_ready, mem_valid, mem_data_out, mem_address_out,
    output outstanding, resp_error
  );

  modport master (
    output r0_read, r0_write, r0_byte_en, r0_address_in, r0_data_in,
    input  r0_ready, r0_valid, r0_data_out, r0_address_out,
    output r1_read, r1_write, r1_byte_en, r1_address_in, r1_data_in,
    input  r1_ready, r1_valid, r1_data_out, r1_address_out,
    input  mem_read, mem_write, mem_byte_en, mem_address_in, mem_data_in,
    output mem_ready, mem_valid, mem_data_out, mem_address_out,
    input  outstanding, resp_error
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core (r0) and
// the host/loader (r1). Requests and responses pass through combinationally;
// a small tag FIFO remembers which requester owns each in-flight read so the
// in-order responses can be steered back to the right side.
module dmem_port_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_BITS    = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic                   clk,
  input logic                   rst,
  dmem_port_arbiter_if.slave    bus
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  logic                       last_grant;
  logic                       resp_error_q;
  logic [CW-1:0]              count;
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic [MAX_OUTSTANDING-1:0] tags;

  logic full, empty;
  logic rd0, rd1, elig0, elig1;
  logic win_valid, win_id, accept, push, pop, head;

  assign full  = (count == CW'(MAX_OUTSTANDING));
  assign empty = (count == '0);

  // A request with both strobes set is a write; reads need a free tag slot.
  // Full is judged on the registered count, so a same-cycle pop does not help.
  assign rd0   = bus.r0_read & ~bus.r0_write;
  assign rd1   = bus.r1_read & ~bus.r1_write;
  assign elig0 = ~rst & (bus.r0_write | (bus.r0_read & ~full));
  assign elig1 = ~rst & (bus.r1_write | (bus.r1_read & ~full));

  // Pick the winner: a lone eligible requester wins, contention goes to the
  // requester that was not granted last.
  // NOTE: every output of an always_comb gets a value on every path (here via
  // the first assignments), otherwise synthesis infers a latch.
  always_comb begin
    win_valid = elig0 | elig1;
    win_id    = elig1;
    if (elig0 && elig1) win_id = ~last_grant;
  end

  // Drive the memory request from the winner, all zero when nobody wins.
  always_comb begin
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_byte_en    = '0;
    bus.mem_address_in = '0;
    bus.mem_data_in    = '0;
    if (win_valid) begin
      if (win_id) begin
        bus.mem_read       = rd1;
        bus.mem_write      = bus.r1_write;
        bus.mem_byte_en    = bus.r1_byte_en;
        bus.mem_address_in = bus.r1_address_in;
        bus.mem_data_in    = bus.r1_data_in;
      end else begin
        bus.mem_read       = rd0;
        bus.mem_write      = bus.r0_write;
        bus.mem_byte_en    = bus.r0_byte_en;
        bus.mem_address_in = bus.r0_address_in;
        bus.mem_data_in    = bus.r0_data_in;
      end
    end
  end

  assign accept       = win_valid & bus.mem_ready;
  assign bus.r0_ready = accept & ~win_id;
  assign bus.r1_ready = accept & win_id;
  assign push         = accept & (win_id ? rd1 : rd0);

  // Response steering: the FIFO head names the owner of the next response.
  assign head         = tags[rd_ptr];
  assign pop          = ~rst & bus.mem_valid & ~empty;
  assign bus.r0_valid = pop & ~head;
  assign bus.r1_valid = pop & head;

  assign bus.r0_data_out    = bus.mem_data_out;
  assign bus.r1_data_out    = bus.mem_data_out;
  assign bus.r0_address_out = bus.mem_address_out;
  assign bus.r1_address_out = bus.mem_address_out;

  assign bus.outstanding = count;
  assign bus.resp_error  = resp_error_q;

  // Arbitration history, FIFO pointers, occupancy and the stray-response flag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant   <= 1'b1;
      resp_error_q <= 1'b0;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      if (accept) last_grant <= win_id;
      if (push)   wr_ptr     <= wr_ptr + PW'(1);
      if (pop)    rd_ptr     <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (bus.mem_valid && empty) resp_error_q <= 1'b1;
    end
  end

  // Tag storage: owner of each accepted read, written at the tail.
  // NOTE: the storage itself is not reset; emptiness is defined by the reset
  // pointers and count, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push) tags[wr_ptr] <= win_id;
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: a table of directed vectors,
// hand-written corner sequences and a randomized run against a queue model.
module tb_dmem_port_arbiter;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int MAX = 4;
  localparam logic [31:0] R0A = 32'h0000_0100, R0D = 32'h0000_00D0;
  localparam logic [31:0] R1A = 32'h0000_0002, R1D = 32'h0F0E_0D0C;
  localparam logic [3:0]  R0B = 4'h3, R1B = 4'hF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  dmem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW), .MAX_OUTSTANDING(MAX)) bus ();

  dmem_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW), .MAX_OUTSTANDING(MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r0r, r0w, r1r, r1w, mrdy, mval;
    logic [31:0] mdata;
    logic        rdy0, rdy1;
    logic [1:0]  win;      // 0, 1 or 2 = no winner
    logic        mrd, mwr, v0, v1;
    logic [2:0]  out_after;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0r, r0w, r1r, r1w, mrdy, mval, input logic [31:0] mdata);
    bus.r0_read = r0r; bus.r0_write = r0w;
    bus.r1_read = r1r; bus.r1_write = r1w;
    bus.mem_ready = mrdy; bus.mem_valid = mval;
    bus.mem_data_out = mdata;
  endtask

  task automatic set_fields();
    bus.r0_address_in = R0A; bus.r0_data_in = R0D; bus.r0_byte_en = R0B;
    bus.r1_address_in = R1A; bus.r1_data_in = R1D; bus.r1_byte_en = R1B;
    bus.mem_address_out = 32'h0000_0055;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  vec_t vecs [10];

  // model state for the randomized run
  bit   mq[$];
  int   m_last;
  bit   m_err;

  initial begin
    set_fields();
    drive(1, 0, 1, 0, 1, 0, 32'h0);
    @(posedge clk);
    #1;
    // Reset with requests present: everything quiet.
    rst = 1'b1;
    #1;
    check("rst r0_ready", 32'(bus.r0_ready), 0);
    check("rst r1_ready", 32'(bus.r1_ready), 0);
    check("rst mem_read", 32'(bus.mem_read), 0);
    check("rst outstanding", 32'(bus.outstanding), 0);
    check("rst resp_error", 32'(bus.resp_error), 0);
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    tick();
    rst = 1'b0;

    // ---------------- table-driven vectors, applied from reset ----------------
    //          r0r r0w r1r r1w rdy val data          rdy0 rdy1 win rd wr v0 v1 out
    vecs[0] = '{0, 0, 0, 1, 1, 0, 32'h0,          0, 1, 2'd1, 0, 1, 0, 0, 3'd0};
    vecs[1] = '{0, 0, 0, 0, 1, 0, 32'h0,          0, 0, 2'd2, 0, 0, 0, 0, 3'd0};
    vecs[2] = '{1, 0, 1, 0, 1, 0, 32'h0,          1, 0, 2'd0, 1, 0, 0, 0, 3'd1};
    vecs[3] = '{1, 0, 1, 0, 1, 0, 32'h0,          0, 1, 2'd1, 1, 0, 0, 0, 3'd2};
    vecs[4] = '{1, 0, 1, 0, 1, 1, 32'hAAAA_0000, 1, 0, 2'd0, 1, 0, 1, 0, 3'd2};
    vecs[5] = '{1, 0, 1, 0, 0, 1, 32'hBBBB_0000, 0, 0, 2'd1, 1, 0, 0, 1, 3'd1};
    vecs[6] = '{1, 0, 1, 0, 0, 0, 32'h0,          0, 0, 2'd1, 1, 0, 0, 0, 3'd1};
    vecs[7] = '{1, 1, 0, 0, 1, 0, 32'h0,          1, 0, 2'd0, 0, 1, 0, 0, 3'd1};
    vecs[8] = '{0, 0, 0, 0, 1, 1, 32'hCCCC_0000, 0, 0, 2'd2, 0, 0, 1, 0, 3'd0};
    vecs[9] = '{0, 0, 0, 0, 1, 1, 32'hDDDD_0000, 0, 0, 2'd2, 0, 0, 0, 0, 3'd0};

    for (int i = 0; i < 10; i++) begin
      vec_t v;
      logic [31:0] ea, ed;
      logic [3:0]  eb;
      v = vecs[i];
      ea = (v.win == 2'd0) ? R0A : (v.win == 2'd1) ? R1A : 32'h0;
      ed = (v.win == 2'd0) ? R0D : (v.win == 2'd1) ? R1D : 32'h0;
      eb = (v.win == 2'd0) ? R0B : (v.win == 2'd1) ? R1B : 4'h0;
      drive(v.r0r, v.r0w, v.r1r, v.r1w, v.mrdy, v.mval, v.mdata);
      #1;
      check($sformatf("vec%0d r0_ready", i), 32'(bus.r0_ready), 32'(v.rdy0));
      check($sformatf("vec%0d r1_ready", i), 32'(bus.r1_ready), 32'(v.rdy1));
      check($sformatf("vec%0d mem_read", i), 32'(bus.mem_read), 32'(v.mrd));
      check($sformatf("vec%0d mem_write", i), 32'(bus.mem_write), 32'(v.mwr));
      check($sformatf("vec%0d mem_address_in", i), bus.mem_address_in, ea);
      check($sformatf("vec%0d mem_data_in", i), bus.mem_data_in, ed);
      check($sformatf("vec%0d mem_byte_en", i), 32'(bus.mem_byte_en), 32'(eb));
      check($sformatf("vec%0d r0_valid", i), 32'(bus.r0_valid), 32'(v.v0));
      check($sformatf("vec%0d r1_valid", i), 32'(bus.r1_valid), 32'(v.v1));
      check($sformatf("vec%0d r0_data_out", i), bus.r0_data_out, v.mdata);
      check($sformatf("vec%0d r1_address_out", i), bus.r1_address_out, 32'h55);
      tick();
      check($sformatf("vec%0d outstanding", i), 32'(bus.outstanding), 32'(v.out_after));
    end
    check("table resp_error sticky", 32'(bus.resp_error), 1);

    // ---------------- FIFO full ----------------
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 1, 0, 32'h0);
      #1;
      check($sformatf("full read%0d r0_ready", i), 32'(bus.r0_ready), 1);
      tick();
    end
    check("full outstanding", 32'(bus.outstanding), 4);
    drive(1, 0, 0, 1, 1, 0, 32'h0);
    #1;
    check("full 5th r0_ready", 32'(bus.r0_ready), 0);
    check("full r1 write ready", 32'(bus.r1_ready), 1);
    check("full mem_write", 32'(bus.mem_write), 1);
    check("full mem_read", 32'(bus.mem_read), 0);
    tick();
    check("full after write", 32'(bus.outstanding), 4);
    drive(1, 0, 0, 0, 1, 1, 32'h1234_5678);
    #1;
    check("full pop r0_ready", 32'(bus.r0_ready), 0);
    check("full pop r0_valid", 32'(bus.r0_valid), 1);
    tick();
    check("full after pop", 32'(bus.outstanding), 3);
    drive(1, 0, 0, 0, 1, 0, 32'h0);
    #1;
    check("full retry r0_ready", 32'(bus.r0_ready), 1);
    tick();
    check("full refilled", 32'(bus.outstanding), 4);

    // ---------------- response routing: tags 1, 0, 0 ----------------
    do_reset();
    drive(0, 0, 1, 0, 1, 0, 32'h0); #1;
    check("route r1 accept", 32'(bus.r1_ready), 1);
    tick();
    drive(1, 0, 0, 0, 1, 0, 32'h0); #1;
    check("route r0 accept a", 32'(bus.r0_ready), 1);
    tick(); #1;
    check("route r0 accept b", 32'(bus.r0_ready), 1);
    tick();
    check("route outstanding", 32'(bus.outstanding), 3);
    drive(0, 0, 0, 0, 1, 1, 32'hAAAA_0001); #1;
    check("route resp1 r1_valid", 32'(bus.r1_valid), 1);
    check("route resp1 r0_valid", 32'(bus.r0_valid), 0);
    check("route resp1 data", bus.r1_data_out, 32'hAAAA_0001);
    tick();
    drive(0, 0, 0, 0, 1, 1, 32'hBBBB_0002); #1;
    check("route resp2 r0_valid", 32'(bus.r0_valid), 1);
    check("route resp2 r1_valid", 32'(bus.r1_valid), 0);
    check("route resp2 data", bus.r0_data_out, 32'hBBBB_0002);
    tick();
    drive(0, 0, 0, 0, 1, 1, 32'hCCCC_0003); #1;
    check("route resp3 r0_valid", 32'(bus.r0_valid), 1);
    check("route resp3 data", bus.r0_data_out, 32'hCCCC_0003);
    tick();
    drive(0, 0, 0, 0, 1, 0, 32'h0);
    check("route drained", 32'(bus.outstanding), 0);
    check("route no error", 32'(bus.resp_error), 0);

    // ---------------- stray response ----------------
    do_reset();
    drive(0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF); #1;
    check("stray r0_valid", 32'(bus.r0_valid), 0);
    check("stray r1_valid", 32'(bus.r1_valid), 0);
    tick();
    drive(0, 0, 0, 0, 1, 0, 32'h0);
    check("stray resp_error set", 32'(bus.resp_error), 1);
    check("stray outstanding", 32'(bus.outstanding), 0);
    tick(); tick();
    check("stray resp_error sticky", 32'(bus.resp_error), 1);

    // ---------------- reset mid-operation ----------------
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 1, 0, 32'h0);
      tick();
    end
    check("midrst outstanding before", 32'(bus.outstanding), 3);
    drive(1, 0, 1, 0, 1, 1, 32'h0);
    #1;
    rst = 1'b1;
    #1;
    check("midrst outstanding", 32'(bus.outstanding), 0);
    check("midrst r0_ready", 32'(bus.r0_ready), 0);
    check("midrst r1_ready", 32'(bus.r1_ready), 0);
    check("midrst mem_read", 32'(bus.mem_read), 0);
    check("midrst r0_valid", 32'(bus.r0_valid), 0);
    check("midrst r1_valid", 32'(bus.r1_valid), 0);
    check("midrst resp_error", 32'(bus.resp_error), 0);
    drive(1, 0, 1, 0, 1, 0, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("midrst first contention r0", 32'(bus.r0_ready), 1);
    check("midrst first contention r1", 32'(bus.r1_ready), 0);
    tick();

    // ---------------- randomized run against a queue model ----------------
    do_reset();
    mq.delete();
    m_last = 1;
    m_err  = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      bit r0r, r0w, r1r, r1w, mrdy, mval;
      bit e0, e1, pop_now;
      int win;
      logic [31:0] mdata, ea;
      r0r  = ($urandom_range(0, 99) < 45);
      r0w  = ($urandom_range(0, 99) < 20);
      r1r  = ($urandom_range(0, 99) < 45);
      r1w  = ($urandom_range(0, 99) < 20);
      mrdy = ($urandom_range(0, 99) < 70);
      mval = (mq.size() > 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 2);
      mdata = $urandom();
      bus.r0_address_in = $urandom(); bus.r0_data_in = $urandom(); bus.r0_byte_en = 4'($urandom());
      bus.r1_address_in = $urandom(); bus.r1_data_in = $urandom(); bus.r1_byte_en = 4'($urandom());
      drive(r0r, r0w, r1r, r1w, mrdy, mval, mdata);

      // spec rules: a write is always eligible, a read needs a free slot
      e0 = r0w || (r0r && mq.size() < MAX);
      e1 = r1w || (r1r && mq.size() < MAX);
      if (e0 && e1)  win = 1 - m_last;
      else if (e0)   win = 0;
      else if (e1)   win = 1;
      else           win = -1;
      ea = (win == 0) ? bus.r0_address_in : (win == 1) ? bus.r1_address_in : 32'h0;
      pop_now = mval && (mq.size() > 0);

      #1;
      check($sformatf("rnd%0d r0_ready", c), 32'(bus.r0_ready), 32'(win == 0 && mrdy));
      check($sformatf("rnd%0d r1_ready", c), 32'(bus.r1_ready), 32'(win == 1 && mrdy));
      check($sformatf("rnd%0d mem_write", c), 32'(bus.mem_write),
            32'((win == 0 && r0w) || (win == 1 && r1w)));
      check($sformatf("rnd%0d mem_read", c), 32'(bus.mem_read),
            32'((win == 0 && r0r && !r0w) || (win == 1 && r1r && !r1w)));
      check($sformatf("rnd%0d mem_address_in", c), bus.mem_address_in, ea);
      check($sformatf("rnd%0d r0_valid", c), 32'(bus.r0_valid), 32'(pop_now && mq[0] == 1'b0));
      check($sformatf("rnd%0d r1_valid", c), 32'(bus.r1_valid), 32'(pop_now && mq[0] == 1'b1));

      if (pop_now) void'(mq.pop_front());
      else if (mval) m_err = 1'b1;
      if (win >= 0 && mrdy) begin
        m_last = win;
        if (win == 0 && r0r && !r0w) mq.push_back(1'b0);
        if (win == 1 && r1r && !r1w) mq.push_back(1'b1);
      end
      tick();
      check($sformatf("rnd%0d outstanding", c), 32'(bus.outstanding), 32'(mq.size()));
      check($sformatf("rnd%0d resp_error", c), 32'(bus.resp_error), 32'(m_err));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-requester arbiter sharing the single data-memory port of `dual_port_BRAM_memory_subsystem` between the `skivav` core (requester 0) and a host/loader engine (requester 1). The loader preloads key, plaintext and random words and reads back ciphertext without stalling the core indefinitely. Requests are granted round-robin. A tag FIFO records which requester owns each in-flight read so that read responses are routed back in order.

## Interface
- DATA_WIDTH, 32, data bus width; byte enables are DATA_WIDTH/8 bits.
- ADDRESS_BITS, 32, address width.
- MAX_OUTSTANDING, 4, maximum in-flight reads; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rN_read, rN_write  in  1  request strobes, N∈{0,1}.
- rN_byte_en  in  DATA_WIDTH/8  write byte enables.
- rN_address_in  in  ADDRESS_BITS  request address.
- rN_data_in  in  DATA_WIDTH  write data.
- rN_ready  out  1  request accepted this cycle.
- rN_valid  out  1  read response for requester N.
- rN_data_out  out  DATA_WIDTH  response data; copy of mem_data_out.
- rN_address_out  out  ADDRESS_BITS  response address; copy of mem_address_out.
- mem_read, mem_write  out  1  request to the memory.
- mem_byte_en, mem_address_in, mem_data_in  out  request fields to the memory.
- mem_ready  in  1  memory accepts a request this cycle.
- mem_valid  in  1  read response from the memory, in request order.
- mem_data_out, mem_address_out  in  response fields.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  number of reads in flight.
- resp_error  out  1  sticky flag: a response arrived while no read was tracked.

## Operation
- **Request from N:** reqN = rN_read | rN_write. If both strobes are asserted, the request is forwarded as a write only and no tag is pushed.
- **Eligibility:** a read request is eligible only when outstanding < MAX_OUTSTANDING. Write requests are always eligible.
- **Grant (combinational):**
  - Only one requester eligible → it wins.
  - Both eligible → the requester other than last_grant wins.
  - last_grant resets to 1, so requester 0 wins the first contention.
- **Mem side:** the mem_* request fields are a mux of the winner's fields. When there is no winner, mem_read = mem_write = 0 and all other request fields are 0.
- **Accept:** rN_ready = (winner == N) & mem_ready. No other condition gates ready.
- **On accept:**
  - last_grant ← N.
  - If the accepted request is a read, push tag N into the FIFO.
  - Writes push nothing and produce no response.
- **Response:**
  - While the FIFO is non-empty: rN_valid = mem_valid & (head == N), and the head is popped when mem_valid is high.
  - rN_data_out and rN_address_out always carry mem_data_out and mem_address_out.
- **Stray response:** mem_valid while the FIFO is empty sets resp_error. Both rN_valid stay 0 and the response is dropped. resp_error clears only on rst.
- **Counter:** outstanding = push − pop each cycle. A push and a pop in the same cycle leave it unchanged.
- **FIFO storage:** circular buffer; read and write pointers wrap modulo MAX_OUTSTANDING.
- **Full:**
  - Full means outstanding == MAX_OUTSTANDING.
  - A read is blocked when the FIFO is full, even if a pop happens in the same cycle.
  - A write from the other requester may still be granted while the FIFO is full.

## Timing
- The request path and the response path are both purely combinational: 0-cycle latency through the arbiter.
- Tag push, pop, counter and last_grant update at the rising clk edge.
- **Reset (asynchronous):**
  - FIFO emptied, outstanding = 0, last_grant = 1, resp_error = 0.
  - With rst high, every output is 0: all rN_ready, rN_valid, mem_read and mem_write are 0.
  - Responses still in flight from before reset arrive to an empty FIFO, are dropped and set resp_error. Software must quiesce the port before resetting.
- **No starvation:** under continuous contention with both requesters eligible, grants alternate every accepted cycle. Requester 0 waits at most one accepted transfer.
- **Back-pressure:** a request held while mem_ready = 0 keeps its grant, and last_grant does not change.

## Test plan
- **Single write:** after reset, r1 writes address 0x2, data 0x0F0E0D0C, byte_en 0xF with mem_ready = 1 → r1_ready = 1 in the same cycle; mem_write = 1 with matching fields; outstanding stays 0.
- **Contention:** r0 and r1 both read continuously, mem_ready = 1, responses 2 cycles later → grants go 0, 1, 0, 1; each rN_valid pulses with the data for its own address; outstanding peaks at 2.
- **FIFO full:** MAX_OUTSTANDING = 4, mem_valid held low, r0 issues 5 reads → the first 4 are accepted; r0_ready = 0 on the 5th; an r1 write in the same cycle is accepted. After one mem_valid pulse, the 5th read is accepted on the following cycle.
- **Response routing:** tag sequence 1, 0, 0; return 0xAAAA0001, 0xBBBB0002, 0xCCCC0003 → r1 receives 0xAAAA0001; r0 receives the other two, in that order.
- **Stray response:** mem_valid with outstanding = 0 → resp_error = 1 and stays 1; no rN_valid pulse.
- **Reset mid-operation:** rst asserted with 3 reads outstanding → outstanding = 0 and all outputs 0 immediately (asynchronously). After release, the first contention grants r0.
